wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Sits directly downstream of the CPU core's two Wishbone master ports (instruction fetch, data mem).
//  Arbitrates them onto one Wishbone master bus toward the memory/interconnect.
//  Round-robin grant with a per-transaction bus timeout that returns err to the stalled master.
//  Routes ack/err/dat_miso back only to the granted port; the non-granted port is stalled.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles a granted stb may wait for ack/err before forced err; 0 = timeout disabled
//  ADR_W           32   address width, all ports
//  DAT_W           32   data width, all ports; sel width = DAT_W/8
// PORTS
//  clk             in   1      system clock, rising edge
//  rst             in   1      reset, asynchronous, active-high
//  fetch_cyc/stb/we in  1 each fetch-port Wishbone cycle/strobe/write-enable
//  fetch_sel       in   4      fetch byte select
//  fetch_adr       in   ADR_W  fetch address
//  fetch_dat_mosi  in   DAT_W  fetch write data
//  fetch_dat_miso  out  DAT_W  fetch read data
//  fetch_ack/err   out  1 each fetch acknowledge / error
//  mem_*           -    -      identical set for the data-mem port
//  bus_cyc/stb/we  out  1 each downstream cycle/strobe/write-enable
//  bus_sel         out  4      downstream byte select
//  bus_adr         out  ADR_W  downstream address
//  bus_dat_mosi    out  DAT_W  downstream write data
//  bus_dat_miso    in   DAT_W  downstream read data
//  bus_ack/err     in   1 each downstream acknowledge / error
//  grant_mem       out  1      1 = mem port owns bus (debug/perf)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, last_grant=FETCH, timeout count=0; every output 0.
//  FSM: IDLE, OWN_FETCH, OWN_MEM, all state registered.
//   IDLE: if exactly one port has cyc&stb, go to that port's OWN state next cycle.
//     If both request, grant the port != last_grant; after reset mem wins the first tie.
//   OWN_x: bus_* = port x signals; bus_cyc = x_cyc.
//     On entry to OWN_x, last_grant = x.
//     Leave to IDLE on the cycle after x_cyc deasserts.
//     Back-to-back beats under a held cyc keep the grant.
//  Grant latency: request in cycle N (IDLE) -> bus_stb in cycle N+1.
//    After release, minimum one IDLE cycle before the next grant.
//  Return path (combinational): x_ack = bus_ack & own_x; x_err = (bus_err | tmo_err) & own_x.
//    x_dat_miso = bus_dat_miso when own_x, else 0.
//    The non-owner sees ack=err=0 and stays stalled with its signals held.
//  bus_ack/bus_err arriving in IDLE are ignored and never forwarded.
//  Timeout counter, when TIMEOUT_CYCLES > 0:
//    - Clears on grant and on every bus_ack/bus_err.
//    - Increments each cycle with bus_stb & !bus_ack & !bus_err.
//    - Saturates at TIMEOUT_CYCLES.
//    - At count == TIMEOUT_CYCLES: tmo_err=1 to the owner for exactly that cycle, and bus_cyc=bus_stb=0 that cycle.
//    - Counter then clears.
//    - Width: $clog2(TIMEOUT_CYCLES+1).
//  bus_ack and bus_err asserted together: both are forwarded; the master treats it as err.
//  Owner drops cyc mid-wait: bus_cyc falls the same cycle (combinational); state goes to IDLE the next edge.
//  rst mid-transaction: outputs 0 immediately; a pending downstream ack after reset is ignored (IDLE).
// TESTING
//  1. Fetch-only read adr=0x100: IDLE->OWN_FETCH, bus_stb the cycle after request.
//     Slave acks data 0x00000013 -> fetch_ack=1, fetch_dat_miso=0x13; mem_ack stays 0.
//  2. Both request in the same cycle after reset: mem granted first.
//     After mem cyc drops, fetch is granted; a repeat tie then goes to mem (alternation).
//  3. Mem write adr=0x2000, dat=0xDEADBEEF, sel=0xF with a 3-wait-state slave:
//     bus mirrors mem signals for 4 cycles; single mem_ack; fetch held stalled throughout.
//  4. TIMEOUT_CYCLES=8, slave never acks a fetch: fetch_err=1 exactly 8 cycles after grant.
//     bus_cyc=0 that cycle; arbiter returns to IDLE once fetch_cyc drops.
//  5. Assert rst while OWN_MEM is waiting: all bus_* and mem_ack drop the same cycle.
//     A late bus_ack after reset produces no ack on either port.
//  6. Fetch holds cyc for 3 consecutive stb beats: grant is retained across beats.
//     A mem request raised mid-burst is only granted after fetch_cyc falls.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Wishbone classic signal bundle used for both CPU-side ports and the downstream bus.
interface wb_port_arbiter_if #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
);
    logic               cyc;
    logic               stb;
    logic               we;
    logic [DAT_W/8-1:0] sel;
    logic [ADR_W-1:0]   adr;
    logic [DAT_W-1:0]   dat_mosi;
    logic [DAT_W-1:0]   dat_miso;
    logic               ack;
    logic               err;

    modport master (output cyc, stb, we, sel, adr, dat_mosi, input dat_miso, ack, err);
    modport slave  (input cyc, stb, we, sel, adr, dat_mosi, output dat_miso, ack, err);
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter merging the fetch and data-mem Wishbone masters onto one bus,
// with a per-transaction timeout that returns err to a stalled owner.
module wb_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  fetch,
    wb_port_arbiter_if.slave  mem,
    wb_port_arbiter_if.master bus,
    output logic              grant_mem
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_OWN_FETCH = 2'd1;
    localparam logic [1:0] ST_OWN_MEM   = 2'd2;
    localparam logic       LAST_FETCH   = 1'b0;
    localparam logic       LAST_MEM     = 1'b1;

    logic [1:0]         state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               own_fetch, own_mem;
    logic               fetch_req, mem_req;
    logic               tmo_err;

    logic               mux_cyc, mux_stb, mux_we;
    logic [DAT_W/8-1:0] mux_sel;
    logic [ADR_W-1:0]   mux_adr;
    logic [DAT_W-1:0]   mux_dat;

    assign own_fetch = (state_q == ST_OWN_FETCH);
    assign own_mem   = (state_q == ST_OWN_MEM);
    assign fetch_req = fetch.cyc & fetch.stb;
    assign mem_req   = mem.cyc & mem.stb;
    assign grant_mem = own_mem;

    // On a tie the port that did not win last time gets the bus.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_req && mem_req) begin
                    if (last_grant_q == LAST_FETCH) begin
                        state_d      = ST_OWN_MEM;
                        last_grant_d = LAST_MEM;
                    end else begin
                        state_d      = ST_OWN_FETCH;
                        last_grant_d = LAST_FETCH;
                    end
                end else if (fetch_req) begin
                    state_d      = ST_OWN_FETCH;
                    last_grant_d = LAST_FETCH;
                end else if (mem_req) begin
                    state_d      = ST_OWN_MEM;
                    last_grant_d = LAST_MEM;
                end
            end
            ST_OWN_FETCH: if (!fetch.cyc) state_d = ST_IDLE;
            ST_OWN_MEM:   if (!mem.cyc)   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_FETCH;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        mux_we  = 1'b0;
        mux_sel = '0;
        mux_adr = '0;
        mux_dat = '0;
        if (own_fetch) begin
            mux_cyc = fetch.cyc;
            mux_stb = fetch.stb;
            mux_we  = fetch.we;
            mux_sel = fetch.sel;
            mux_adr = fetch.adr;
            mux_dat = fetch.dat_mosi;
        end else if (own_mem) begin
            mux_cyc = mem.cyc;
            mux_stb = mem.stb;
            mux_we  = mem.we;
            mux_sel = mem.sel;
            mux_adr = mem.adr;
            mux_dat = mem.dat_mosi;
        end
    end

    // The timeout cycle withdraws cyc/stb so the slave sees the transfer abandoned.
    assign bus.cyc      = mux_cyc & ~tmo_err;
    assign bus.stb      = mux_stb & ~tmo_err;
    assign bus.we       = mux_we;
    assign bus.sel      = mux_sel;
    assign bus.adr      = mux_adr;
    assign bus.dat_mosi = mux_dat;

    assign fetch.ack      = bus.ack & own_fetch;
    assign fetch.err      = (bus.err | tmo_err) & own_fetch;
    assign fetch.dat_miso = own_fetch ? bus.dat_miso : '0;
    assign mem.ack        = bus.ack & own_mem;
    assign mem.err        = (bus.err | tmo_err) & own_mem;
    assign mem.dat_miso   = own_mem ? bus.dat_miso : '0;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);

            logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
            logic             grant_start;

            assign grant_start = (state_q == ST_IDLE) && (fetch_req || mem_req);
            assign tmo_err     = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_MAX);

            always_comb begin
                tmo_cnt_d = tmo_cnt_q;
                if (grant_start || bus.ack || bus.err || tmo_err) begin
                    tmo_cnt_d = '0;
                end else if (mux_stb && (tmo_cnt_q != TMO_MAX)) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) tmo_cnt_q <= '0;
                else     tmo_cnt_q <= tmo_cnt_d;
            end
        end else begin : g_no_tmo
            assign tmo_err = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: port responses go through a scoreboard queue,
// bus-side timing and grant behaviour are checked directly.
module tb_wb_port_arbiter;
    logic clk;
    logic rst;
    logic grant_mem;

    wb_port_arbiter_if #(.ADR_W(32), .DAT_W(32)) fetch_if ();
    wb_port_arbiter_if #(.ADR_W(32), .DAT_W(32)) mem_if ();
    wb_port_arbiter_if #(.ADR_W(32), .DAT_W(32)) bus_if ();

    wb_port_arbiter #(.TIMEOUT_CYCLES(8), .ADR_W(32), .DAT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fetch_if.slave),
        .mem       (mem_if.slave),
        .bus       (bus_if.master),
        .grant_mem (grant_mem)
    );

    int checks = 0;
    int errors = 0;

    // Expected port responses packed as {ack, err, dat_miso}.
    logic [33:0] fetch_q[$];
    logic [33:0] mem_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit to_mem, input logic cyc, input logic stb, input logic we,
                                 input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        if (to_mem) begin
            mem_if.cyc = cyc; mem_if.stb = stb; mem_if.we = we;
            mem_if.sel = sel; mem_if.adr = adr; mem_if.dat_mosi = dat;
        end else begin
            fetch_if.cyc = cyc; fetch_if.stb = stb; fetch_if.we = we;
            fetch_if.sel = sel; fetch_if.adr = adr; fetch_if.dat_mosi = dat;
        end
    endtask

    task automatic slaveDrive(input logic ack, input logic err, input logic [31:0] dat);
        bus_if.ack = ack;
        bus_if.err = err;
        bus_if.dat_miso = dat;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearAll();
        applyStimulus(1'b0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        slaveDrive(0, 0, 32'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearAll();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: any ack/err on a port must match the next queued expectation.
    always @(negedge clk) begin
        if (fetch_if.ack || fetch_if.err) begin
            if (fetch_q.size() == 0)
                checkOutput("fetch_unexpected_resp", {62'h0, fetch_if.ack, fetch_if.err}, 64'h0);
            else
                checkOutput("fetch_resp", {30'h0, fetch_if.ack, fetch_if.err, fetch_if.dat_miso},
                            {30'h0, fetch_q.pop_front()});
        end
        if (mem_if.ack || mem_if.err) begin
            if (mem_q.size() == 0)
                checkOutput("mem_unexpected_resp", {62'h0, mem_if.ack, mem_if.err}, 64'h0);
            else
                checkOutput("mem_resp", {30'h0, mem_if.ack, mem_if.err, mem_if.dat_miso},
                            {30'h0, mem_q.pop_front()});
        end
    end

    initial begin
        rst = 1'b1;
        clearAll();
        applyStimulus(1'b0, 1, 1, 0, 4'hF, 32'h100, 32'h0);
        @(negedge clk);
        checkOutput("rst_bus_cyc", bus_if.cyc, 0);
        checkOutput("rst_bus_stb", bus_if.stb, 0);
        checkOutput("rst_bus_adr", bus_if.adr, 0);
        checkOutput("rst_grant_mem", grant_mem, 0);
        doReset();

        // Test 1: fetch-only read
        applyStimulus(1'b0, 1, 1, 0, 4'hF, 32'h100, 32'h0);
        @(negedge clk);
        checkOutput("t1_idle_stb", bus_if.stb, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t1_grant_stb", bus_if.stb, 1);
        checkOutput("t1_grant_adr", bus_if.adr, 32'h100);
        checkOutput("t1_grant_mem", grant_mem, 0);
        nextCycle();
        slaveDrive(1, 0, 32'h13);
        fetch_q.push_back({1'b1, 1'b0, 32'h13});
        @(negedge clk);
        checkOutput("t1_mem_ack", mem_if.ack, 0);
        nextCycle();
        slaveDrive(0, 0, 32'h0);
        applyStimulus(1'b0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t1_cyc_drop", bus_if.cyc, 0);
        nextCycle();

        // Test 2: tie after reset goes to mem, then alternation
        doReset();
        applyStimulus(1'b0, 1, 1, 0, 4'hF, 32'h300, 32'h0);
        applyStimulus(1'b1, 1, 1, 0, 4'hF, 32'h400, 32'h0);
        @(negedge clk);
        checkOutput("t2_idle_grant", grant_mem, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t2_first_grant_mem", grant_mem, 1);
        checkOutput("t2_first_adr", bus_if.adr, 32'h400);
        nextCycle();
        slaveDrive(1, 0, 32'hA5);
        mem_q.push_back({1'b1, 1'b0, 32'hA5});
        nextCycle();
        slaveDrive(0, 0, 32'h0);
        applyStimulus(1'b1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t2_mem_release_cyc", bus_if.cyc, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t2_gap_stb", bus_if.stb, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t2_fetch_grant_mem", grant_mem, 0);
        checkOutput("t2_fetch_stb", bus_if.stb, 1);
        checkOutput("t2_fetch_adr", bus_if.adr, 32'h300);
        nextCycle();
        slaveDrive(1, 0, 32'h5A);
        fetch_q.push_back({1'b1, 1'b0, 32'h5A});
        nextCycle();
        slaveDrive(0, 0, 32'h0);
        applyStimulus(1'b0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1, 1, 0, 4'hF, 32'h300, 32'h0);
        applyStimulus(1'b1, 1, 1, 0, 4'hF, 32'h400, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("t2_second_tie_mem", grant_mem, 1);
        checkOutput("t2_second_tie_adr", bus_if.adr, 32'h400);
        nextCycle();
        clearAll();
        repeat (2) nextCycle();

        // Test 3: mem write with three wait states, fetch stalled
        applyStimulus(1'b1, 1, 1, 1, 4'hF, 32'h2000, 32'hDEADBEEF);
        nextCycle();
        applyStimulus(1'b0, 1, 1, 0, 4'hF, 32'h500, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                slaveDrive(1, 0, 32'h0);
                mem_q.push_back({1'b1, 1'b0, 32'h0});
            end
            @(negedge clk);
            checkOutput($sformatf("t3_we_%0d", i), bus_if.we, 1);
            checkOutput($sformatf("t3_adr_%0d", i), bus_if.adr, 32'h2000);
            checkOutput($sformatf("t3_dat_%0d", i), bus_if.dat_mosi, 32'hDEADBEEF);
            checkOutput($sformatf("t3_sel_%0d", i), bus_if.sel, 4'hF);
            checkOutput($sformatf("t3_grant_%0d", i), grant_mem, 1);
            checkOutput($sformatf("t3_fetch_stall_%0d", i), fetch_if.ack, 0);
            nextCycle();
        end
        slaveDrive(0, 0, 32'h0);
        applyStimulus(1'b1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("t3_fetch_after_grant", grant_mem, 0);
        checkOutput("t3_fetch_after_adr", bus_if.adr, 32'h500);
        slaveDrive(1, 0, 32'h77);
        fetch_q.push_back({1'b1, 1'b0, 32'h77});
        nextCycle();
        slaveDrive(0, 0, 32'h0);
        applyStimulus(1'b0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (2) nextCycle();

        // Test 4: fetch timeout after 8 cycles
        applyStimulus(1'b0, 1, 1, 0, 4'hF, 32'h600, 32'h0);
        nextCycle();
        for (int c = 0; c <= 8; c++) begin
            if (c == 8) fetch_q.push_back({1'b0, 1'b1, 32'h0});
            @(negedge clk);
            if (c < 8) begin
                checkOutput($sformatf("t4_no_err_%0d", c), fetch_if.err, 0);
                checkOutput($sformatf("t4_cyc_%0d", c), bus_if.cyc, 1);
            end else begin
                checkOutput("t4_tmo_err", fetch_if.err, 1);
                checkOutput("t4_tmo_cyc", bus_if.cyc, 0);
                checkOutput("t4_tmo_stb", bus_if.stb, 0);
            end
            nextCycle();
        end
        applyStimulus(1'b0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t4_after_err", fetch_if.err, 0);
        nextCycle();
        applyStimulus(1'b1, 1, 1, 0, 4'hF, 32'h700, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("t4_idle_then_mem", grant_mem, 1);
        slaveDrive(1, 0, 32'h3C);
        mem_q.push_back({1'b1, 1'b0, 32'h3C});
        nextCycle();
        clearAll();
        repeat (2) nextCycle();

        // Test 5: reset while mem owns the bus
        applyStimulus(1'b1, 1, 1, 0, 4'hF, 32'h800, 32'h0);
        nextCycle();
        nextCycle();
        slaveDrive(1, 0, 32'h99);
        #1;
        checkOutput("t5_pre_rst_ack", mem_if.ack, 1);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_cyc", bus_if.cyc, 0);
        checkOutput("t5_rst_stb", bus_if.stb, 0);
        checkOutput("t5_rst_adr", bus_if.adr, 0);
        checkOutput("t5_rst_grant", grant_mem, 0);
        checkOutput("t5_rst_mem_ack", mem_if.ack, 0);
        nextCycle();
        applyStimulus(1'b1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        nextCycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t5_late_mem_ack_%0d", i), mem_if.ack, 0);
            checkOutput($sformatf("t5_late_fetch_ack_%0d", i), fetch_if.ack, 0);
            nextCycle();
        end
        clearAll();
        nextCycle();

        // Test 6: fetch burst keeps grant; mid-burst mem waits
        applyStimulus(1'b0, 1, 1, 0, 4'hF, 32'h200, 32'h0);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            fetch_if.adr = 32'h200 + 32'(4 * i);
            slaveDrive(1, 0, 32'h10 + 32'(i));
            fetch_q.push_back({1'b1, 1'b0, 32'h10 + 32'(i)});
            if (i == 1) applyStimulus(1'b1, 1, 1, 0, 4'hF, 32'h900, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("t6_grant_%0d", i), grant_mem, 0);
            checkOutput($sformatf("t6_adr_%0d", i), bus_if.adr, 32'h200 + 32'(4 * i));
            checkOutput($sformatf("t6_stb_%0d", i), bus_if.stb, 1);
            nextCycle();
        end
        applyStimulus(1'b0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        slaveDrive(0, 0, 32'h0);
        @(negedge clk);
        checkOutput("t6_release_grant", grant_mem, 0);
        checkOutput("t6_release_cyc", bus_if.cyc, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t6_idle_grant", grant_mem, 0);
        checkOutput("t6_idle_stb", bus_if.stb, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t6_mem_grant", grant_mem, 1);
        checkOutput("t6_mem_adr", bus_if.adr, 32'h900);
        slaveDrive(1, 0, 32'h44);
        mem_q.push_back({1'b1, 1'b0, 32'h44});
        nextCycle();
        clearAll();
        repeat (2) nextCycle();

        checkOutput("fetch_q_drained", 64'(fetch_q.size()), 0);
        checkOutput("mem_q_drained", 64'(mem_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
